// File: rtl/rv_iopmp_pkg.sv
// Shared IOPMP types and constants: access types, error codes and the
// state encoding of the sequential source-enforcement decision logic.
package rv_iopmp_pkg;

  typedef logic [2:0] access_t;

  localparam access_t ACCESS_READ      = 3'd1;
  localparam access_t ACCESS_WRITE     = 3'd2;
  localparam access_t ACCESS_EXECUTION = 3'd3;

  localparam logic [2:0] ERR_READ    = 3'd1;
  localparam logic [2:0] ERR_WRITE   = 3'd2;
  localparam logic [2:0] ERR_EXEC    = 3'd3;
  localparam logic [2:0] ERR_NOT_HIT = 3'd5;
  localparam logic [2:0] ERR_UNKNOWN = 3'd7;

  typedef enum logic [1:0] {
    SE_IDLE = 2'd0,
    SE_SCAN = 2'd1,
    SE_RESP = 2'd2
  } se_seq_state_e;

  // Error code reported when an entry denies an access of the given type.
  function automatic logic [2:0] err_type_of(access_t access);
    case (access)
      ACCESS_READ:      err_type_of = ERR_READ;
      ACCESS_WRITE:     err_type_of = ERR_WRITE;
      ACCESS_EXECUTION: err_type_of = ERR_EXEC;
      default:          err_type_of = ERR_UNKNOWN;
    endcase
  endfunction

endpackage

// File: rtl/rv_iopmp_prio_enc.sv
// Lowest-index priority encoder: reports whether any lane is set and the
// index of the lowest set lane.
module rv_iopmp_prio_enc #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] req,
  output logic             hit,
  output logic [IDX_W-1:0] index
);

  // Walk from the top lane down so the lowest set lane is written last.
  always_comb begin
    hit   = 1'b0;
    index = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (req[i]) begin
        hit   = 1'b1;
        index = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/rv_iopmp_dl_se_seq.sv
// Sequential source-enforcement decision logic: scans the entry table one
// window per cycle and answers with the decision of the first matching entry.
module rv_iopmp_dl_se_seq
  import rv_iopmp_pkg::*;
#(
  parameter int unsigned NUMBER_ENTRIES   = 16,
  parameter int unsigned NUMBER_INSTANCES = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        req_valid_i,
  output logic                        req_ready_o,
  input  logic                        enable_i,
  input  access_t                     access_type_i,
  output logic [15:0]                 entry_offset_o,
  input  logic [NUMBER_INSTANCES-1:0] entry_match_i,
  input  logic [NUMBER_INSTANCES-1:0] entry_allow_i,
  output logic                        rsp_valid_o,
  input  logic                        rsp_ready_i,
  output logic                        allow_transaction_o,
  output logic                        err_transaction_o,
  output logic [2:0]                  err_type_o,
  output logic [15:0]                 err_entry_index_o
);

  localparam int unsigned NUM_WINDOWS = (NUMBER_ENTRIES + NUMBER_INSTANCES - 1) / NUMBER_INSTANCES;
  localparam int unsigned WIN_W       = (NUM_WINDOWS > 1) ? $clog2(NUM_WINDOWS) : 1;
  localparam int unsigned LANE_W      = (NUMBER_INSTANCES > 1) ? $clog2(NUMBER_INSTANCES) : 1;

  se_seq_state_e               state;
  logic [WIN_W-1:0]            win;
  access_t                     access_q;
  logic                        allow_q;
  logic                        err_q;
  logic [2:0]                  type_q;
  logic [15:0]                 index_q;

  logic [15:0]                 offset;
  logic [NUMBER_INSTANCES-1:0] lane_valid;
  logic [NUMBER_INSTANCES-1:0] lane_match;
  logic                        hit;
  logic [LANE_W-1:0]           hit_lane;
  logic                        hit_allow;
  logic [15:0]                 hit_index;
  logic                        last_win;

  assign offset = 16'(win) * 16'(NUMBER_INSTANCES);

  // Lanes past the end of the table (partial last window) never match; the
  // sum is taken in 17 bits so it cannot wrap back into the valid range.
  always_comb begin
    lane_valid = '0;
    for (int j = 0; j < NUMBER_INSTANCES; j++) begin
      lane_valid[j] = (17'(offset) + 17'(j)) < 17'(NUMBER_ENTRIES);
    end
  end

  assign lane_match = entry_match_i & lane_valid;

  rv_iopmp_prio_enc #(
    .WIDTH (NUMBER_INSTANCES),
    .IDX_W (LANE_W)
  ) u_prio_enc (
    .req   (lane_match),
    .hit   (hit),
    .index (hit_lane)
  );

  assign hit_allow = entry_allow_i[hit_lane];
  assign hit_index = offset + 16'(hit_lane);
  assign last_win  = (win == WIN_W'(NUM_WINDOWS - 1));

  // Decision registers stay zero everywhere except RESP, so the outputs can
  // be driven straight from them.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= SE_IDLE;
      win      <= '0;
      access_q <= '0;
      allow_q  <= 1'b0;
      err_q    <= 1'b0;
      type_q   <= '0;
      index_q  <= '0;
    end else begin
      case (state)
        SE_IDLE: begin
          if (req_valid_i) begin
            access_q <= access_type_i;
            win      <= '0;
            state    <= enable_i ? SE_SCAN : SE_RESP;
          end
        end
        SE_SCAN: begin
          if (hit) begin
            state   <= SE_RESP;
            allow_q <= hit_allow;
            err_q   <= !hit_allow;
            type_q  <= hit_allow ? 3'd0 : err_type_of(access_q);
            index_q <= hit_allow ? 16'd0 : hit_index;
          end else if (last_win) begin
            state   <= SE_RESP;
            allow_q <= 1'b0;
            err_q   <= 1'b1;
            type_q  <= ERR_NOT_HIT;
            index_q <= '0;
          end else begin
            win <= win + 1'b1;
          end
        end
        SE_RESP: begin
          if (rsp_ready_i) begin
            state   <= SE_IDLE;
            allow_q <= 1'b0;
            err_q   <= 1'b0;
            type_q  <= '0;
            index_q <= '0;
          end
        end
        default: state <= SE_IDLE;
      endcase
    end
  end

  assign req_ready_o         = (state == SE_IDLE);
  assign rsp_valid_o         = (state == SE_RESP);
  assign entry_offset_o      = (state == SE_SCAN) ? offset : 16'd0;
  assign allow_transaction_o = allow_q;
  assign err_transaction_o   = err_q;
  assign err_type_o          = type_q;
  assign err_entry_index_o   = index_q;

endmodule
